// File: rtl/div64.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div64
// Description : Multi-cycle 64-bit integer divider for RV64M DIV, DIVU, REM
//               and REMU. Radix-2 restoring division retiring one quotient
//               bit per cycle, with a start/done handshake toward the
//               execute-stage controller. Division by zero and signed
//               overflow follow the RISC-V M-extension rules.
//
// Ports       : clk     in   1      clock, rising-edge
//               reset   in   1      synchronous active-high reset
//               start   in   1      request, sampled only while idle
//               op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//               a       in   WIDTH  dividend, sampled with start
//               b       in   WIDTH  divisor, sampled with start
//               busy    out  1      high from cycle after accept until done
//               done    out  1      single-cycle pulse, result valid
//               result  out  WIDTH  quotient (op[1]=0) or remainder (op[1]=1)
//
// Options     : DIV64_EARLY_OUT_EN - when defined, b = 0, signed overflow and
//               |a| < |b| complete in one cycle straight from idle. When not
//               defined every operation takes the full 66-cycle path.
//
// Revision    : 1.0 - initial release
// ============================================================================
module div64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;       // partial remainder
    logic [WIDTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dvs;       // divisor magnitude
    logic [WIDTH-1:0]   r_a;         // original dividend, the remainder for b = 0
    logic               r_sel_rem;   // op[1]: return remainder instead of quotient
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_result;

    // ------------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------------
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_early_result;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    // Magnitudes are treated as unsigned, so the most negative value maps
    // onto 2^(WIDTH-1) without overflow.
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = w_signed & (a == c_MIN) & (b == '1);

`ifdef DIV64_EARLY_OUT_EN
    logic [WIDTH-1:0] w_early_q;
    logic [WIDTH-1:0] w_early_r;

    // b = 0 cannot satisfy the magnitude compare and the overflow pair has
    // |a| > |b|, so the three cases never overlap.
    assign w_early   = w_b_zero | w_ovf | (w_a_mag < w_b_mag);
    assign w_early_q = w_b_zero ? '1 : (w_ovf ? c_MIN : '0);
    assign w_early_r = w_ovf ? '0 : a;
    assign w_early_result = op[1] ? w_early_r : w_early_q;
`else
    assign w_early        = 1'b0;
    assign w_early_result = '0;
`endif

    // ------------------------------------------------------------------------
    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The 65-bit difference has its top bit set exactly when the shifted
    // remainder is below the divisor, so that bit is the inverted quotient bit.
    // ------------------------------------------------------------------------
    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_rem_sub;
    logic           w_q_bit;

    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_dvs};
    assign w_q_bit     = ~w_rem_sub[WIDTH];

    // ------------------------------------------------------------------------
    // Sign correction and special values. Signed overflow needs no special
    // case: 2^63 / 1 negated is -2^63 again, with a zero remainder.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;

    assign w_fix_q = r_b_zero ? '1  : (r_neg_q ? -r_quo : r_quo);
    assign w_fix_r = r_b_zero ? r_a : (r_neg_r ? -r_rem : r_rem);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = w_early ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_FIX;
                end
            end
            c_FIX:   w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_a       <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_dvs     <= w_b_mag;
                        r_a       <= a;
                        r_sel_rem <= op[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_b_zero  <= w_b_zero;
                        if (w_early) begin
                            r_result <= w_early_result;
                        end
                    end
                end
                c_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_rem <= w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                end
                c_FIX: begin
                    r_result <= r_sel_rem ? w_fix_r : w_fix_q;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy   = (r_state == c_CALC) | (r_state == c_FIX);
    assign done   = (r_state == c_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/div64.md
# div64

Multi-cycle 64-bit integer divider for the RV64M DIV/DIVU/REM/REMU instructions, the subtractive counterpart of the combinational 64-bit adder in the execute stage. It uses a radix-2 restoring algorithm that retires one quotient bit per cycle, with a start/done handshake toward the execute-stage controller. Results follow the RISC-V M-extension rules, including division by zero and signed overflow.

## Interface
- WIDTH, 64, operand and result width; only 64 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  64  dividend; sampled with start.
- b  in  64  divisor; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; result is valid.
- result  out  64  quotient (op[1]=0) or remainder (op[1]=1); held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + start: latch op, record signs, and take |a| and |b| for signed ops (magnitudes treated as unsigned, so |−2^63| = 2^63).
  - Clear the remainder register and the iteration counter; go to CALC.
  - With early-out, go to DONE when the early-out conditions apply (see Configuration).
- CALC, once per cycle (64 cycles, counter 0..63):
  - Shift the remainder left one bit, inserting the dividend MSB.
  - If remainder ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - After iteration 63, go to FIX.
- FIX, sign correction and special values:
  - Signed op with differing operand signs: negate the quotient.
  - Signed op with a negative dividend: negate the remainder.
  - b = 0: force quotient = all ones; remainder = a.
  - a = −2^63, b = −1, DIV/REM: quotient = −2^63, remainder = 0. The algorithm produces this naturally; it must hold.
  - Select quotient or remainder into result; go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0; go to IDLE.
- start outside IDLE is ignored; it is neither queued nor allowed to corrupt the operation in progress.
- Operands may change after the accepting cycle without effect.

## Timing
- Reset values: busy = 0, done = 0, result = 0, state IDLE, counter 0.
- Start asserted in cycle 0 (IDLE): busy is high in cycles 1..65, done is high in cycle 66, and a new start is accepted from cycle 67.
- Early-out path (macro enabled): done is high in cycle 1; busy stays 0.
- Back-to-back: start asserted in the same cycle as done is ignored; the controller reasserts it in the cycle after done.
- Reset mid-operation aborts with no done pulse. The next cycle is IDLE with all outputs at reset values.
- result changes only on the DONE transition and on reset.

## Configuration
- DIV64_EARLY_OUT_EN defined: from IDLE, the following complete in 1 cycle:
  - b = 0: quotient all ones, remainder a.
  - Signed overflow: quotient −2^63, remainder 0.
  - |a| < |b| (unsigned compare on magnitudes): quotient 0, remainder a.
- DIV64_EARLY_OUT_EN undefined: every operation takes the full 66-cycle path, with identical result values.

## Test plan
- DIVU a=100, b=7 → done in cycle 66, result 14; REMU with the same operands → result 2.
- DIV a=−100, b=7 → result −14 (0xFFFFFFFFFFFFFFF2); REM → result −2; REM a=100, b=−7 → result 2.
- DIV a=5, b=0 → 0xFFFFFFFFFFFFFFFF; REMU a=5, b=0 → 5. Cycle 1 with the macro, cycle 66 without.
- DIV a=0x8000000000000000, b=−1 → 0x8000000000000000; REM with the same operands → 0.
- start pulsed again in cycle 30 with different operands → ignored, and the original result is returned in cycle 66. Reset asserted in cycle 40 → no done pulse, and all outputs read 0 in cycle 41.
- Random 10k-operation regression of all four ops against a reference model, including |a| < |b| cases (DIVU 3/9 → 0, REMU 3/9 → 3).
